// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: decode / operand-fetch stage between IF/ID and execute.
// Drives register-file read addresses and captures operands into the ID/EX
// register. A 32-entry scoreboard tracks in-flight destinations and stalls
// issue on RAW/WAW hazards.
// Optional feature macro: OPF_WB_BYPASS_EN. When defined, same-cycle writeback
// data is forwarded into the operands and resolves the hazard that cycle.
module operand_fetch_stage #(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic [31:0]            id_instr,
    input  logic [XLEN-1:0]        id_pc,
    output logic [4:0]             rf_rs1_addr,
    output logic [4:0]             rf_rs2_addr,
    input  logic [XLEN-1:0]        rf_rs1_dout,
    input  logic [XLEN-1:0]        rf_rs2_dout,
    input  logic                   wb_we,
    input  logic [4:0]             wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   flush,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [31:0]            ex_instr,
    output logic [XLEN-1:0]        ex_pc,
    output logic [XLEN-1:0]        ex_rs1,
    output logic [XLEN-1:0]        ex_rs2,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic                   ex_valid_q, ex_valid_d;
    logic [31:0]            ex_instr_q;
    logic [XLEN-1:0]        ex_pc_q, ex_rs1_q, ex_rs2_q;
    logic [31:0]            busy_q, busy_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    // Decode of the incoming instruction
    logic [6:0] opc;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_used, rs2_used, rd_we;

    assign opc      = id_instr[6:0];
    assign rd       = id_instr[11:7];
    assign rs1      = id_instr[19:15];
    assign rs2      = id_instr[24:20];
    assign rs1_used = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    assign rs2_used = (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
    assign rd_we    = !(opc == OPC_STORE || opc == OPC_BRANCH) && (rd != 5'd0);

    // Decode of the instruction held in ID/EX, needed to release it on flush
    logic [6:0] ex_opc;
    logic [4:0] ex_rd;
    logic       ex_rd_we;

    assign ex_opc   = ex_instr_q[6:0];
    assign ex_rd    = ex_instr_q[11:7];
    assign ex_rd_we = !(ex_opc == OPC_STORE || ex_opc == OPC_BRANCH) && (ex_rd != 5'd0);

    // Same-cycle writeback forwarding; tied off when the feature is compiled out
    logic byp1, byp2, bypd;
`ifdef OPF_WB_BYPASS_EN
    assign byp1 = wb_we && (wb_rd == rs1) && (rs1 != 5'd0);
    assign byp2 = wb_we && (wb_rd == rs2) && (rs2 != 5'd0);
    assign bypd = wb_we && (wb_rd == rd);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
    assign bypd = 1'b0;
`endif

    logic [XLEN-1:0] op1, op2;
    assign op1 = byp1 ? wb_data : rf_rs1_dout;
    assign op2 = byp2 ? wb_data : rf_rs2_dout;

    logic hazard, space, issue, kill_held;
    assign hazard = (rs1_used && busy_q[rs1] && !byp1) ||
                    (rs2_used && busy_q[rs2] && !byp2) ||
                    (rd_we    && busy_q[rd]  && !bypd);
    assign space     = !ex_valid_q || ex_ready;
    assign id_ready  = space && !hazard && !flush;
    assign issue     = id_valid && id_ready;
    // Flushed instruction that execute never took must give its rd back
    assign kill_held = flush && ex_valid_q && !ex_ready && ex_rd_we;

    // Next-state for valid bit, scoreboard and stall counter
    always_comb begin
        ex_valid_d = ex_valid_q;
        if (issue)
            ex_valid_d = 1'b1;
        else if (space || flush)
            ex_valid_d = 1'b0;

        busy_d = busy_q;
        for (int r = 1; r < 32; r++) begin
            if (issue && rd_we && (rd == 5'(r)))
                busy_d[r] = 1'b1;
            else if (wb_we && (wb_rd == 5'(r)))
                busy_d[r] = 1'b0;
            if (kill_held && (ex_rd == 5'(r)))
                busy_d[r] = 1'b0;
        end
        busy_d[0] = 1'b0;

        stall_d = stall_q;
        if (id_valid && hazard && !flush && !(&stall_q))
            stall_d = stall_q + 1'b1;
    end

    // ID/EX register, scoreboard and stall counter state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q <= 1'b0;
            ex_instr_q <= '0;
            ex_pc_q    <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            busy_q     <= '0;
            stall_q    <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            busy_q     <= busy_d;
            stall_q    <= stall_d;
            if (issue) begin
                ex_instr_q <= id_instr;
                ex_pc_q    <= id_pc;
                ex_rs1_q   <= op1;
                ex_rs2_q   <= op2;
            end
        end
    end

    assign rf_rs1_addr  = rs1;
    assign rf_rs2_addr  = rs2;
    assign ex_valid     = ex_valid_q;
    assign ex_instr     = ex_instr_q;
    assign ex_pc        = ex_pc_q;
    assign ex_rs1       = ex_rs1_q;
    assign ex_rs2       = ex_rs2_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage. Models a register file (x_i resets
// to 0x100+i) and checks handshake, hazards, bypass, backpressure and flush.
module tb_operand_fetch_stage;

`ifdef OPF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_dout, rf_rs2_dout;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_instr, ex_pc, ex_rs1, ex_rs2;
    logic [15:0] stall_cycles;

    logic [31:0] regs [32];
    int n_chk = 0;
    int n_fail = 0;

    operand_fetch_stage #(.XLEN(32), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_dout(rf_rs1_dout), .rf_rs2_dout(rf_rs2_dout),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr),
        .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Register file: combinational read, write on clock edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'h0 : 32'h100 + 32'(i);
        end else if (wb_we && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end
    assign rf_rs1_dout = regs[rf_rs1_addr];
    assign rf_rs2_dout = regs[rf_rs2_addr];

    function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction
    function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'h0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction
    function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'h0, rs1, 3'b010, rd, 7'h03};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] pc);
        id_instr = ins;
        id_pc    = pc;
        id_valid = 1'b1;
    endtask

    task automatic do_reset();
        id_valid = 1'b0;
        wb_we    = 1'b0;
        flush    = 1'b0;
        rst      = 1'b0;
        #1;
        rst      = 1'b1;
    endtask

    initial begin
        rst = 1'b0; id_valid = 1'b0; id_instr = '0; id_pc = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; ex_ready = 1'b1;
        #2;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_instr", ex_instr, 32'd0);
        chk("rst_stall", 32'(stall_cycles), 32'd0);
        tick();
        rst = 1'b1;

        // ---- asynchronous reset mid-run
        ex_ready = 1'b0;
        present(i_lw(5, 0), 32'h40);
        settle(); chk("mr_rdy0", 32'(id_ready), 32'd1);
        tick();
        present(i_add(9, 5, 0), 32'h44);
        settle(); chk("mr_haz", 32'(id_ready), 32'd0);
        tick();
        chk("mr_exv", 32'(ex_valid), 32'd1);
        chk("mr_stall", 32'(stall_cycles), 32'd1);
        rst = 1'b0;
        #1;
        chk("mr_rst_exv", 32'(ex_valid), 32'd0);
        chk("mr_rst_stall", 32'(stall_cycles), 32'd0);
        chk("mr_rst_pc", ex_pc, 32'd0);
        #1;
        rst = 1'b1;
        settle(); chk("mr_busy_clr", 32'(id_ready), 32'd1);
        tick();
        id_valid = 1'b0;

        // ---- back-to-back independent
        do_reset();
        ex_ready = 1'b1;
        present(i_addi(1, 0, 5), 32'h100);
        settle(); chk("b2b_rdy1", 32'(id_ready), 32'd1);
        tick();
        chk("b2b_v1", 32'(ex_valid), 32'd1);
        chk("b2b_i1", ex_instr, i_addi(1, 0, 5));
        chk("b2b_pc1", ex_pc, 32'h100);
        chk("b2b_rs1_1", ex_rs1, 32'h0);
        present(i_addi(2, 0, 7), 32'h104);
        settle(); chk("b2b_rdy2", 32'(id_ready), 32'd1);
        tick();
        chk("b2b_v2", 32'(ex_valid), 32'd1);
        chk("b2b_i2", ex_instr, i_addi(2, 0, 7));
        chk("b2b_pc2", ex_pc, 32'h104);
        present(i_add(10, 11, 12), 32'h108);
        settle(); chk("b2b_addr1", 32'(rf_rs1_addr), 32'd11);
        chk("b2b_addr2", 32'(rf_rs2_addr), 32'd12);
        tick();
        chk("b2b_v3", 32'(ex_valid), 32'd1);
        chk("b2b_rs1_3", ex_rs1, 32'h10B);
        chk("b2b_rs2_3", ex_rs2, 32'h10C);
        id_valid = 1'b0;
        tick();
        chk("b2b_idle", 32'(ex_valid), 32'd0);
        chk("b2b_stall", 32'(stall_cycles), 32'd0);

        // ---- RAW hazard with writeback
        do_reset();
        ex_ready = 1'b1;
        present(i_addi(3, 0, 1), 32'h300);
        tick();
        present(i_add(4, 3, 3), 32'h304);
        settle(); chk("raw_stall_a", 32'(id_ready), 32'd0);
        tick();
        settle(); chk("raw_stall_b", 32'(id_ready), 32'd0);
        tick();
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
        settle(); chk("raw_wb_rdy", 32'(id_ready), 32'(BYP));
        tick();
        wb_we = 1'b0;
        if (BYP) begin
            chk("raw_byp_i", ex_instr, i_add(4, 3, 3));
            chk("raw_byp_rs1", ex_rs1, 32'h11);
            chk("raw_byp_rs2", ex_rs2, 32'h11);
            chk("raw_byp_stall", 32'(stall_cycles), 32'd2);
        end else begin
            settle(); chk("raw_post_rdy", 32'(id_ready), 32'd1);
            chk("raw_stall", 32'(stall_cycles), 32'd3);
            tick();
            chk("raw_i", ex_instr, i_add(4, 3, 3));
            chk("raw_rs1", ex_rs1, 32'h11);
            chk("raw_rs2", ex_rs2, 32'h11);
        end
        id_valid = 1'b0;

        // ---- backpressure
        do_reset();
        ex_ready = 1'b1;
        present(i_addi(1, 0, 5), 32'h200);
        tick();
        chk("bp_v", 32'(ex_valid), 32'd1);
        ex_ready = 1'b0;
        present(i_addi(2, 0, 7), 32'h204);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("bp_rdy", 32'(id_ready), 32'd0);
            chk("bp_instr", ex_instr, i_addi(1, 0, 5));
            chk("bp_pc", ex_pc, 32'h200);
            chk("bp_valid", 32'(ex_valid), 32'd1);
            tick();
        end
        chk("bp_stall", 32'(stall_cycles), 32'd0);
        ex_ready = 1'b1;
        settle(); chk("bp_release", 32'(id_ready), 32'd1);
        tick();
        chk("bp_next", ex_instr, i_addi(2, 0, 7));
        chk("bp_next_pc", ex_pc, 32'h204);
        id_valid = 1'b0;

        // ---- WAW and x0
        do_reset();
        ex_ready = 1'b1;
        present(i_lw(6, 0), 32'h500);
        tick();
        present(i_addi(6, 0, 3), 32'h504);
        settle(); chk("waw_stall", 32'(id_ready), 32'd0);
        tick();
        wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'h66;
        settle(); chk("waw_wb_rdy", 32'(id_ready), 32'(BYP));
        tick();
        wb_we = 1'b0;
        if (BYP) begin
            chk("waw_byp_i", ex_instr, i_addi(6, 0, 3));
            chk("waw_byp_stall", 32'(stall_cycles), 32'd1);
        end else begin
            settle(); chk("waw_post_rdy", 32'(id_ready), 32'd1);
            chk("waw_stall_n", 32'(stall_cycles), 32'd2);
            tick();
            chk("waw_i", ex_instr, i_addi(6, 0, 3));
        end
        present(i_addi(0, 0, 1), 32'h508);
        settle(); chk("x0_rdy", 32'(id_ready), 32'd1);
        tick();
        present(i_add(7, 0, 0), 32'h50C);
        settle(); chk("x0_dep_rdy", 32'(id_ready), 32'd1);
        tick();
        chk("x0_dep_i", ex_instr, i_add(7, 0, 0));
        chk("x0_dep_rs1", ex_rs1, 32'h0);
        chk("x0_stall", 32'(stall_cycles), BYP ? 32'd1 : 32'd2);
        id_valid = 1'b0;

        // ---- flush of a held instruction
        do_reset();
        ex_ready = 1'b0;
        present(i_addi(8, 0, 9), 32'h600);
        settle(); chk("fl_rdy", 32'(id_ready), 32'd1);
        tick();
        chk("fl_held", 32'(ex_valid), 32'd1);
        present(i_add(9, 8, 0), 32'h604);
        flush = 1'b1;
        settle(); chk("fl_block", 32'(id_ready), 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_exv", 32'(ex_valid), 32'd0);
        settle(); chk("fl_busy_clr", 32'(id_ready), 32'd1);
        tick();
        chk("fl_issue_v", 32'(ex_valid), 32'd1);
        chk("fl_issue_i", ex_instr, i_add(9, 8, 0));
        chk("fl_issue_rs1", ex_rs1, 32'h108);
        chk("fl_stall", 32'(stall_cycles), 32'd0);
        id_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage sitting between the IF/ID buffer and execute.
- Drives the register file read addresses and captures rs1/rs2 read data into an ID/EX pipeline register.
- Tracks in-flight destination registers in a scoreboard and stalls on RAW/WAW hazards.
- Optionally bypasses same-cycle writeback data.

Parameters:
- XLEN, 32, data/PC width.
- STALL_CNT_W, 16, width of saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- id_valid  in  1  instruction available from IF/ID.
- id_ready  out  1  stage accepts id_instr this cycle.
- id_instr  in  32  raw RV32I instruction.
- id_pc  in  XLEN  PC of id_instr.
- rf_rs1_addr  out  5  register file read port 1 address = id_instr[19:15], combinational.
- rf_rs2_addr  out  5  register file read port 2 address = id_instr[24:20], combinational.
- rf_rs1_dout  in  XLEN  register file read data 1 (combinational read).
- rf_rs2_dout  in  XLEN  register file read data 2.
- wb_we  in  1  writeback commits this cycle (same signal drives register file we).
- wb_rd  in  5  writeback destination.
- wb_data  in  XLEN  writeback data.
- flush  in  1  squash held instruction, block issue.
- ex_valid  out  1  ID/EX register holds a valid instruction.
- ex_ready  in  1  execute consumes ID/EX this cycle.
- ex_instr  out  32  registered instruction.
- ex_pc  out  XLEN  registered PC.
- ex_rs1  out  XLEN  registered rs1 operand.
- ex_rs2  out  XLEN  registered rs2 operand.
- stall_cycles  out  STALL_CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset: all outputs and state are cleared asynchronously.
  - ex_valid=0; ex_instr, ex_pc, ex_rs1, ex_rs2 = 0.
  - busy[31:0]=0; stall_cycles=0.
- Decode fields:
  - opc=instr[6:0], rd=instr[11:7].
  - rs1_used: opc not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
  - rs2_used: opc in {0110011, 0100011, 1100011}.
  - rd_we: opc not in {0100011, 1100011} and rd!=0.
- Register x0 is never busy and is never bypassed.
- hazard = (rs1_used & busy[rs1] & !byp1) | (rs2_used & busy[rs2] & !byp2) | (rd_we & busy[rd] & !bypd).
  - byp1, byp2 and bypd are defined under Optional Feature; all are 0 when it is compiled out.
- Handshake:
  - space = !ex_valid | ex_ready.
  - id_ready = space & !hazard & !flush.
  - issue = id_valid & id_ready.
- On issue, ID/EX loads instr, pc and the operands next edge; ex_valid=1. Latency: 1 cycle from acceptance to ex_valid.
- If space & !issue, ex_valid goes to 0 next edge.
- If !space, ID/EX holds all values; rf_rs*_addr continue to track id_instr.
- Scoreboard, per edge, per register r:
  - set if issue & rd_we & rd==r;
  - else clear if wb_we & wb_rd==r;
  - set has priority over clear on the same register.
- flush:
  - ex_valid goes to 0 next edge.
  - If the held instruction had rd_we and was not consumed this cycle (ex_valid & !ex_ready), its busy bit clears. This clear has priority over wb set/clear of the same register.
  - No issue occurs in the flush cycle.
- stall_cycles increments, saturating at all-ones, on each cycle with id_valid & hazard & !flush.
- An asynchronous reset mid-operation discards the ID/EX register and the whole scoreboard immediately.

Optional Feature:
- Macro: OPF_WB_BYPASS_EN.
- Defined:
  - byp1 = wb_we & wb_rd==rs1 & rs1!=0. If byp1, ex_rs1 captures wb_data, else rf_rs1_dout.
  - byp2 is defined the same way for rs2.
  - bypd = wb_we & wb_rd==rd. The WAW hazard is cleared in the same cycle; the set wins, so the reg stays busy.
  - A dependent instruction issues in the writeback cycle.
- Undefined:
  - byp*=0 and operands always come from rf_rs*_dout.
  - A dependent instruction stalls until the cycle after the wb_we edge.

Test Plan:
- Reset: rst=0 mid-run with ex_valid=1, busy[5]=1 -> ex_valid=0, busy=0 and stall_cycles=0 immediately; id_ready=1 once id_valid is presented.
- Back-to-back independent: "addi x1,x0,5" then "addi x2,x0,7" with ex_ready=1 -> one issue per cycle, ex_valid continuous, stall_cycles=0.
- RAW hazard: issue "addi x3,x0,1", then present "add x4,x3,x3"; wb_we pulse with rd=3, data=0x11 two cycles later:
  - without macro: id_ready=0 until the cycle after wb; ex_rs1=ex_rs2=0x11 taken from the regfile; stall_cycles=3.
  - with macro: issue occurs in the wb cycle; stall_cycles=2.
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* outputs stable, id_ready=0; stall_cycles unchanged (backpressure is not a hazard).
- WAW and x0: "lw x6" outstanding, then "addi x6,..." stalls. "addi x0,x0,1" never sets busy; a following "add x7,x0,x0" issues without stall.
- Flush: hold "addi x8,..." with ex_ready=0, assert flush -> ex_valid=0 next cycle, busy[8]=0; an instruction reading x8 then issues immediately.
